// File: rtl/wb_uart_tx.sv
// Wishbone B4 byte-write UART transmitter: FIFO-buffered writes, 8N1 serial output.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and stop.
`timescale 1ns/1ps
module wb_uart_tx #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        tx_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;
  state_e        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
`ifdef UART_TX_PARITY_EN
  logic          par_q;
`endif

  logic empty, full, req, pop, push, baud_end;
  logic unused_ok;

  // Address is decoded upstream and only the low byte of write data is used.
  assign unused_ok = ^{wb_adr_i, wb_dat_i[31:8]};

  function automatic logic [31:0] status_word(input logic [CW-1:0] cnt,
                                              input logic e, input logic f,
                                              input logic b);
    logic [8:0] c9;
    logic [7:0] c8;
    c9 = 9'(cnt);
    c8 = (c9 > 9'd255) ? 8'hFF : c9[7:0];
    return {16'b0, c8, 5'b0, e, f, b};
  endfunction

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(FIFO_DEPTH));
    req      = wb_cyc_i & wb_stb_i & ~ack_q;
    pop      = (state_q == S_IDLE) & ~empty;
    // A full FIFO still accepts the byte in a cycle where the head is popped.
    push     = req & wb_we_i & (~full | pop);
    ack_d    = req & (~wb_we_i | push);
    dat_d    = (req & ~wb_we_i) ? status_word(count_q, empty, full, state_q != S_IDLE) : '0;
    baud_end = (baud_q == BW'(CLK_DIV - 1));
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wb_dat_i[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          if (pop) begin
            state_q <= S_START;
            tx_q    <= 1'b0;
            shift_q <= mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            par_q   <= ^mem_q[rd_ptr_q];
`endif
          end
        end
        S_START: begin
          if (baud_end) begin
            state_q <= S_DATA;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              tx_q    <= par_q;
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_end) begin
            state_q <= S_STOP;
            baud_q  <= '0;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (baud_end) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          baud_q  <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign tx_o     = tx_q;

endmodule
